// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-ROM port, redirect port and decode-side handshake.
// The master modport belongs to the fetch queue; the slave modport is its environment.
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] irom_addr;
    logic [XLEN-1:0] irom_data;
    logic            dnpc_flag;
    logic [XLEN-1:0] dnpc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_snpc;
    logic [XLEN-1:0] out_inst;
    logic [CW-1:0]   count;

    modport master (
        output irom_addr,
        input  irom_data,
        input  dnpc_flag,
        input  dnpc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_snpc,
        output out_inst,
        output count
    );

    modport slave (
        input  irom_addr,
        output irom_data,
        output dnpc_flag,
        output dnpc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_snpc,
        input  out_inst,
        input  count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: streams sequential PCs to the ROM and buffers
// {pc, snpc, inst} in a circular queue drained by decode; a redirect flushes everything.
module fetch_queue #(
    parameter int unsigned         XLEN     = 32,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [XLEN-1:0]     RESET_PC = 32'h8000_0000
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    fetch_queue_if.master fq
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] snpc;
        logic [XLEN-1:0] inst;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            req_pending;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;

    logic            push;
    logic            pop;
    logic            issue;
    logic [CW:0]     reserved;

    // A slot is reserved for every outstanding ROM request, so a response always finds room.
    always_comb begin
        push     = req_pending;
        pop      = fq.out_valid && fq.out_ready;
        reserved = (CW+1)'(count_q) + (CW+1)'(req_pending) - (CW+1)'(pop);
        issue    = !fq.dnpc_flag && (reserved < (CW+1)'(DEPTH));
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            req_pending <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (fq.dnpc_flag) begin
            // Redirect drops queued entries and the response still in flight.
            fetch_pc    <= fq.dnpc;
            req_pending <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
        end else begin
            req_pending <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                mem[wr_ptr] <= '{pc: req_pc, snpc: req_pc + XLEN'(4), inst: fq.irom_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Head is hidden during a redirect so decode never accepts a stale entry.
    always_comb begin
        fq.irom_addr = fetch_pc;
        fq.out_valid = (count_q != '0) && !fq.dnpc_flag;
        fq.out_pc    = mem[rd_ptr].pc;
        fq.out_snpc  = mem[rd_ptr].snpc;
        fq.out_inst  = mem[rd_ptr].inst;
        fq.count     = count_q;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_fetch_queue;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .fq      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    // ROM answers one cycle after the address is presented.
    always @(posedge clk) bus.irom_data <= rom_word(bus.irom_addr);

    // Reference model: decode-visible queue, one optional request in flight, next fetch address.
    logic [31:0] mq[$];
    bit          m_inflight;
    logic [31:0] m_inflight_pc;
    logic [31:0] m_fpc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        bus.dnpc_flag = 1'b0;
        bus.dnpc      = '0;
        mq.delete();
        m_inflight    = 1'b0;
        m_fpc         = RESET_PC;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rdy, input bit flg, input logic [31:0] tgt);
        bit exp_valid;
        bit pop;
        bit iss;
        int occ;
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = rdy;
        bus.dnpc_flag = flg;
        bus.dnpc      = tgt;
        #1;
        exp_valid = !flg && (mq.size() != 0);
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("count", 32'(bus.count), 32'(mq.size()));
        check("irom_addr", bus.irom_addr, m_fpc);
        if (exp_valid) begin
            check("out_pc", bus.out_pc, mq[0]);
            check("out_snpc", bus.out_snpc, mq[0] + 32'd4);
            check("out_inst", bus.out_inst, rom_word(mq[0]));
        end
        pop = exp_valid && rdy;
        if (flg) begin
            mq.delete();
            m_inflight = 1'b0;
            m_fpc      = tgt;
        end else begin
            occ = mq.size() + int'(m_inflight) - int'(pop);
            if (pop) void'(mq.pop_front());
            if (m_inflight) mq.push_back(m_inflight_pc);
            iss           = occ < int'(DEPTH);
            m_inflight    = iss;
            m_inflight_pc = m_fpc;
            if (iss) m_fpc = m_fpc + 32'd4;
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        bus.dnpc_flag = 1'b0;
        bus.dnpc      = '0;

        // Streaming with decode always ready: first head two cycles after reset.
        do_reset();
        step(1'b1, 1'b0, '0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_snpc", bus.out_snpc, 32'h0);
        check("rst_out_inst", bus.out_inst, 32'h0);
        check("rst_irom_addr", bus.irom_addr, RESET_PC);
        step(1'b1, 1'b0, '0);
        check("fill_valid_c1", 32'(bus.out_valid), 32'd0);
        step(1'b1, 1'b0, '0);
        check("fill_valid_c2", 32'(bus.out_valid), 32'd1);
        check("first_pc", bus.out_pc, RESET_PC);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // Decode stalled: queue saturates and issue stops, then drains in order.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check("stall_count", 32'(bus.count), DEPTH);
        check("stall_addr", bus.irom_addr, RESET_PC + 32'h10);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);

        // Redirect with two entries queued.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        check("pre_redirect_count", 32'(bus.count), 32'd2);
        step(1'b1, 1'b1, 32'h8000_0100);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // Redirect with a response in flight, then two back-to-back redirects.
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b0, '0);
        check("b2b_addr", bus.irom_addr, 32'h0000_0300);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("b2b_first_pc", bus.out_pc, 32'h0000_0300);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);

        // Full queue under push+pop, pointer wrap, and fetch address wrap at 2^XLEN.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
        for (int i = 0; i < 4 * DEPTH; i++) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // Reset mid-stream with three entries queued.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
        check("pre_reset_count", 32'(bus.count), 32'd3);
        do_reset();
        step(1'b1, 1'b0, '0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_addr", bus.irom_addr, RESET_PC);

        // Random traffic: ready mostly high, then mostly low; occasional redirects and resets.
        for (int i = 0; i < 3000; i++) begin
            bit          rdy;
            bit          flg;
            logic [31:0] tgt;
            rdy = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flg = ($urandom_range(0, 15) == 0);
            tgt = RESET_PC + 32'($urandom_range(0, 1023)) * 32'd4 + 32'($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(rdy, flg, tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
